// File: rtl/fib_scheduler.sv
// -----------------------------------------------------------------------------
// fib_scheduler
//   Shares one 16-bit fibonacci generator between NREQ requesters. One
//   requester is granted at a time for a burst of L terms (len=0 counts as 1).
//   The scheduler drives the generator enable for L+1 cycles, drops the
//   duplicate term the generator repeats after every pause, and forwards the
//   remaining L terms to the granted consumer with d_last on the final one.
//
// Ports
//   clock_1  in   1        clock for this block and the generator
//   reset    in   1        asynchronous, active-low reset
//   req      in   NREQ     level-sensitive burst requests
//   len      in   NREQ*LW  burst length per requester, field i = len[i*LW +: LW]
//   gnt      out  NREQ     one-hot grant, held for the whole burst
//   busy     out  1        burst in progress
//   f_en     out  1        registered enable to the generator
//   f_valid  in   1        generator term valid
//   f_out    in   DW       generator term
//   d_valid  out  1        forwarded term valid (registered)
//   d_out    out  DW       forwarded term (registered)
//   d_last   out  1        final term of the burst, coincident with d_valid
//   d_id     out  3        index of the granted requester
//
// Configuration macro
//   FIB_SCHED_RR_EN  defined: round-robin arbitration starting after the last
//                    winner; undefined: fixed priority, lowest index wins.
// -----------------------------------------------------------------------------
module fib_scheduler #(
  parameter int NREQ = 2,
  parameter int LW   = 8,
  parameter int DW   = 16
) (
  input  logic                 clock_1,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*LW-1:0]   len,
  output logic [NREQ-1:0]      gnt,
  output logic                 busy,
  output logic                 f_en,
  input  logic                 f_valid,
  input  logic [DW-1:0]        f_out,
  output logic                 d_valid,
  output logic [DW-1:0]        d_out,
  output logic                 d_last,
  output logic [2:0]           d_id
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]      state_q,   state_d;
  logic [NREQ-1:0] gnt_q,     gnt_d;
  logic [2:0]      id_q,      id_d;
  logic            f_en_q,    f_en_d;
  logic [LW-1:0]   en_cnt_q,  en_cnt_d;   // enable cycles still to go after this one
  logic [LW-1:0]   rem_q,     rem_d;      // terms still to forward
  logic            skip_q,    skip_d;     // next f_valid is the post-pause duplicate
  logic            d_valid_q, d_valid_d;
  logic [DW-1:0]   d_out_q,   d_out_d;
  logic            d_last_q,  d_last_d;

  // Per-requester length fields
  logic [LW-1:0] len_field [NREQ];
  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_len
      assign len_field[gi] = len[gi*LW +: LW];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Arbiter: search order is rotated by the pointer in round-robin mode
  // ---------------------------------------------------------------------------
  logic       win_found;
  logic [2:0] win_idx;

`ifdef FIB_SCHED_RR_EN
  logic [2:0] ptr_q, ptr_d;
  logic [3:0] ptr_inc;
  assign ptr_inc = {1'b0, win_idx} + 4'd1;
`endif

  always_comb begin
    logic [3:0] cand;
    cand      = '0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
`ifdef FIB_SCHED_RR_EN
      cand = {1'b0, ptr_q} + 4'(k);
      if (cand >= 4'(NREQ)) cand = cand - 4'(NREQ);
`else
      cand = 4'(k);
`endif
      for (int j = 0; j < NREQ; j++) begin
        if (!win_found && (cand == 4'(j)) && req[j]) begin
          win_found = 1'b1;
          win_idx   = 3'(j);
        end
      end
    end
  end

  // Length of the winner; zero means a single term
  logic [LW-1:0] len_sel;
  logic [LW-1:0] burst_len;

  always_comb begin
    len_sel = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (win_idx == 3'(j)) len_sel = len_field[j];
    end
  end

  assign burst_len = (len_sel == '0) ? LW'(1) : len_sel;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    id_d      = id_q;
    f_en_d    = f_en_q;
    en_cnt_d  = en_cnt_q;
    rem_d     = rem_q;
    skip_d    = skip_q;
    d_valid_d = 1'b0;
    d_out_d   = d_out_q;
    d_last_d  = 1'b0;
`ifdef FIB_SCHED_RR_EN
    ptr_d     = ptr_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d  = S_RUN;
          gnt_d    = {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
          id_d     = win_idx;
          f_en_d   = 1'b1;
          // The first enabled cycle is this grant's own cycle, so loading L
          // yields L+1 enabled cycles in total.
          en_cnt_d = burst_len;
          rem_d    = burst_len;
          skip_d   = 1'b1;
`ifdef FIB_SCHED_RR_EN
          ptr_d    = (ptr_inc >= 4'(NREQ)) ? 3'd0 : ptr_inc[2:0];
`endif
        end
      end
      S_RUN: begin
        if (en_cnt_q == '0) begin
          f_en_d  = 1'b0;
          state_d = S_DRAIN;
        end else begin
          en_cnt_d = en_cnt_q - LW'(1);
        end
      end
      S_DRAIN: begin
        // Terms still trail the enable by a cycle; leave once the last is out.
        if (d_last_q) begin
          state_d = S_IDLE;
          gnt_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
        f_en_d  = 1'b0;
      end
    endcase

    // Forwarding path runs in RUN and DRAIN alike
    if (state_q != S_IDLE && f_valid) begin
      if (skip_q) begin
        skip_d = 1'b0;
      end else if (rem_q != '0) begin
        d_valid_d = 1'b1;
        d_out_d   = f_out;
        d_last_d  = (rem_q == LW'(1));
        rem_d     = rem_q - LW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock_1 or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      gnt_q     <= '0;
      id_q      <= '0;
      f_en_q    <= 1'b0;
      en_cnt_q  <= '0;
      rem_q     <= '0;
      skip_q    <= 1'b0;
      d_valid_q <= 1'b0;
      d_out_q   <= '0;
      d_last_q  <= 1'b0;
`ifdef FIB_SCHED_RR_EN
      ptr_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      id_q      <= id_d;
      f_en_q    <= f_en_d;
      en_cnt_q  <= en_cnt_d;
      rem_q     <= rem_d;
      skip_q    <= skip_d;
      d_valid_q <= d_valid_d;
      d_out_q   <= d_out_d;
      d_last_q  <= d_last_d;
`ifdef FIB_SCHED_RR_EN
      ptr_q     <= ptr_d;
`endif
    end
  end

  assign gnt     = gnt_q;
  assign busy    = (state_q != S_IDLE);
  assign f_en    = f_en_q;
  assign d_valid = d_valid_q;
  assign d_out   = d_out_q;
  assign d_last  = d_last_q;
  assign d_id    = id_q;

endmodule

// File: tb/tb_fib_scheduler.sv
// -----------------------------------------------------------------------------
// tb_fib_scheduler
//   Drives fib_scheduler together with a behavioural fibonacci generator that
//   repeats its previous term after every pause. Expected data is the plain
//   fibonacci sequence (mod 2^16) continued across bursts; expected winners
//   come from the arbitration rules stated directly.
// -----------------------------------------------------------------------------
module tb_fib_scheduler;
  localparam int NREQ = 2;
  localparam int LW   = 8;
  localparam int DW   = 16;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NREQ-1:0]     req = '0;
  logic [NREQ*LW-1:0]  len = '0;
  logic [NREQ-1:0]     gnt;
  logic                busy;
  logic                f_en;
  logic                f_valid;
  logic [DW-1:0]       f_out;
  logic                d_valid;
  logic [DW-1:0]       d_out;
  logic                d_last;
  logic [2:0]          d_id;

  always #5 clk = ~clk;

  fib_scheduler #(.NREQ(NREQ), .LW(LW), .DW(DW)) dut (
    .clock_1 (clk),
    .reset   (rst_n),
    .req     (req),
    .len     (len),
    .gnt     (gnt),
    .busy    (busy),
    .f_en    (f_en),
    .f_valid (f_valid),
    .f_out   (f_out),
    .d_valid (d_valid),
    .d_out   (d_out),
    .d_last  (d_last),
    .d_id    (d_id)
  );

  // Generator stand-in: valid one cycle after enable, repeats last term after a pause
  logic          g_en_prev;
  logic [DW-1:0] g_last, g_a, g_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_valid   <= 1'b0;
      f_out     <= '0;
      g_en_prev <= 1'b0;
      g_last    <= '0;
      g_a       <= '0;
      g_b       <= 16'd1;
    end else begin
      f_valid   <= f_en;
      g_en_prev <= f_en;
      if (f_en) begin
        if (!g_en_prev) begin
          f_out <= g_last;
        end else begin
          f_out  <= g_a;
          g_last <= g_a;
          g_a    <= g_b;
          g_b    <= g_a + g_b;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model state and checking
  // ---------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;
  int fib_idx = 0;             // index of the next term a consumer should see
  int last_win = NREQ - 1;     // so the first round-robin search starts at 0
  logic [15:0] last_term = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] fib(input int n);
    logic [15:0] x, y, t;
    x = 16'd0;
    y = 16'd1;
    for (int i = 0; i < n; i++) begin
      t = x + y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  function automatic int pick(input logic [NREQ-1:0] r);
`ifdef FIB_SCHED_RR_EN
    for (int k = 1; k <= NREQ; k++) begin
      if (r[(last_win + k) % NREQ]) return (last_win + k) % NREQ;
    end
`else
    for (int k = 0; k < NREQ; k++) begin
      if (r[k]) return k;
    end
`endif
    return 0;
  endfunction

  task automatic chk_reset_outputs(input string where);
    chk({where, "_gnt"},     gnt,     0);
    chk({where, "_busy"},    busy,    0);
    chk({where, "_f_en"},    f_en,    0);
    chk({where, "_d_valid"}, d_valid, 0);
    chk({where, "_d_out"},   d_out,   0);
    chk({where, "_d_last"},  d_last,  0);
    chk({where, "_d_id"},    d_id,    0);
  endtask

  task automatic model_reset();
    fib_idx  = 0;
    last_win = NREQ - 1;
  endtask

  // One full burst: request, grant, collect every term, check the hand-back.
  task automatic run_burst(input logic [NREQ-1:0] r, input logic [7:0] l0,
                           input logic [7:0] l1, input logic [NREQ-1:0] r_after);
    int w, lb, n, fc, cyc, hold_bad, first_dv, last_dv;
    req = r;
    len = {l1, l0};
    w = pick(r);
    cyc = 0;
    while (!busy && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("grant_seen", busy, 1);
    if (!busy) return;
    chk("gnt_onehot", gnt, 32'(1 << w));
    chk("d_id", d_id, w);
    last_win = w;
    lb = (w == 0) ? int'(l0) : int'(l1);
    if (lb == 0) lb = 1;
    req = r_after;
    n = 0; fc = 0; cyc = 0; hold_bad = 0; first_dv = 0; last_dv = -1;
    while (busy && cyc < lb + 20) begin
      if (f_en) fc++;
      if (gnt !== NREQ'(1 << w) || d_id !== 3'(w)) hold_bad++;
      if (d_valid) begin
        chk("d_out", d_out, fib(fib_idx + n));
        chk("d_last", d_last, (n == lb - 1));
        if (n == 0) first_dv = cyc;
        last_dv = cyc;
        last_term = d_out;
        n++;
      end
      @(negedge clk);
      cyc++;
    end
    chk("burst_end", busy, 0);
    chk("term_count", n, lb);
    chk("f_en_cycles", fc, lb + 1);
    chk("no_stall", last_dv - first_dv + 1, lb);
    chk("gnt_held", hold_bad, 0);
    chk("gnt_clear", gnt, 0);
    $display("burst req=%b winner=%0d len=%0d terms=%0d first_idx=%0d", r, w, lb, n, fib_idx);
    fib_idx += lb;
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  initial begin
    int seen, cyc;
    logic [NREQ-1:0] rr;
    logic [7:0] rl0, rl1;

    // Reset state, both while held and just after release
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset_held");
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_outputs("reset_release");

    // First burst from reset, then a second requester continuing the sequence
    run_burst(2'b01, 8'd5, 8'd0, 2'b00);
    run_burst(2'b10, 8'd0, 8'd3, 2'b00);

    // Both requesting continuously
    run_burst(2'b11, 8'd2, 8'd2, 2'b11);
    run_burst(2'b11, 8'd2, 8'd2, 2'b11);
    run_burst(2'b11, 8'd2, 8'd2, 2'b11);
    run_burst(2'b11, 8'd2, 8'd2, 2'b00);

    // Zero length means one term
    run_burst(2'b01, 8'd0, 8'd0, 2'b00);

    // Request dropped right after grant: burst still completes
    run_burst(2'b10, 8'd0, 8'd4, 2'b00);

    // Reset while the third term of a five-term burst is on the output
    req = 2'b01;
    len = {8'd0, 8'd5};
    cyc = 0;
    while (!busy && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    seen = 0;
    cyc = 0;
    while (seen < 3 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (d_valid) seen++;
    end
    chk("abort_reach_term3", seen, 3);
    req = '0;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("mid_burst_reset");
    $display("reset asserted mid-burst after %0d terms", seen);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    run_burst(2'b01, 8'd5, 8'd0, 2'b00);

    // Long burst from term 0: 26th term wraps to 9489
    reset_pulse();
    run_burst(2'b01, 8'd26, 8'd0, 2'b00);
    chk("term26_value", last_term, 16'd9489);

    // Randomised bursts checked against the model
    for (int it = 0; it < 16; it++) begin
      rr  = NREQ'($urandom_range(1, 3));
      rl0 = 8'($urandom_range(0, 12));
      rl1 = 8'($urandom_range(0, 12));
      run_burst(rr, rl0, rl1, ($urandom_range(0, 1) == 1) ? rr : 2'b00);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
